// File: rtl/rv32_bus_responder.sv
// Data-bus responder for the rv32 core: byte-writable synchronous RAM plus an
// MMIO bank (LED latch, cycle counter, compare, timer-pending status).
module rv32_bus_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic [31:0] write_value_in,
  input  logic [3:0]  write_mask_in,
  output logic [31:0] read_value_out,
  output logic [7:0]  leds_out,
  output logic        timer_irq_out
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wval,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = wval[8*i +: 8];
    end
    return res;
  endfunction

  logic          wr_en;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_idx;
  logic          addr_unused;

  assign wr_en       = |write_mask_in;
  assign ram_hit     = (address_in[31:AW+2] == RAM_BASE[31:AW+2]);
  assign mmio_hit    = (address_in[31:4] == MMIO_BASE[31:4]);
  assign ram_idx     = address_in[AW+1:2];
  assign reg_idx     = address_in[3:2];
  assign addr_unused = ^address_in[1:0];

  // Stage p1: RAM array, kept free of reset so it maps onto block RAM
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_rd_p1;

  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (write_mask_in[i]) ram[ram_idx][8*i +: 8] <= write_value_in[8*i +: 8];
      end
    end
    ram_rd_p1 <= ram[ram_idx];
  end

  logic [7:0]  leds_q, leds_nx;
  logic [31:0] cycle_q, cycle_nx;
  logic [31:0] cmp_q, cmp_nx;
  logic        pending_q, pending_nx;
  logic [31:0] mmio_rd;
  logic        wr_leds, wr_cycle, wr_cmp, status_clr;

  always_comb begin
    wr_leds    = wr_en && mmio_hit && (reg_idx == 2'd0);
    wr_cycle   = wr_en && mmio_hit && (reg_idx == 2'd1);
    wr_cmp     = wr_en && mmio_hit && (reg_idx == 2'd2);
    status_clr = wr_en && mmio_hit && (reg_idx == 2'd3)
                 && write_mask_in[0] && write_value_in[0];

    leds_nx = leds_q;
    if (wr_leds && write_mask_in[0]) leds_nx = write_value_in[7:0];

    cycle_nx = wr_cycle ? merge_lanes(cycle_q, write_value_in, write_mask_in)
                        : cycle_q + 32'd1;
    cmp_nx   = wr_cmp ? merge_lanes(cmp_q, write_value_in, write_mask_in) : cmp_q;

    // A match on the upcoming values beats a simultaneous software clear
    if (cycle_nx == cmp_nx)  pending_nx = 1'b1;
    else if (status_clr)     pending_nx = 1'b0;
    else                     pending_nx = pending_q;

    mmio_rd = 32'd0;
    case (reg_idx)
      2'd0:    mmio_rd = {24'd0, leds_q};
      2'd1:    mmio_rd = cycle_q;
      2'd2:    mmio_rd = cmp_q;
      default: mmio_rd = {31'd0, pending_q};
    endcase
  end

  // Stage p1: register bank and read-data capture (old values on read-during-write)
  logic        ram_sel_p1;
  logic [31:0] mmio_rd_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_q     <= 8'd0;
      cycle_q    <= 32'd0;
      cmp_q      <= 32'hFFFF_FFFF;
      pending_q  <= 1'b0;
      ram_sel_p1 <= 1'b0;
      mmio_rd_p1 <= 32'd0;
    end else begin
      leds_q     <= leds_nx;
      cycle_q    <= cycle_nx;
      cmp_q      <= cmp_nx;
      pending_q  <= pending_nx;
      ram_sel_p1 <= ram_hit;
      mmio_rd_p1 <= mmio_hit ? mmio_rd : 32'd0;
    end
  end

  assign read_value_out = ram_sel_p1 ? ram_rd_p1 : mmio_rd_p1;
  assign leds_out       = leds_q;
  assign timer_irq_out  = pending_q;

endmodule

// File: tb/tb_rv32_bus_responder.sv
// Bench for rv32_bus_responder: vector table and hand sequences feeding a
// scoreboard queue of expected read data.
module tb_rv32_bus_responder;

  localparam logic [31:0] MMIO = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic [31:0] write_value_in;
  logic [3:0]  write_mask_in;
  logic [31:0] read_value_out;
  logic [7:0]  leds_out;
  logic        timer_irq_out;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  string       nm_q[$];

  rv32_bus_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .write_value_in (write_value_in),
    .write_mask_in  (write_mask_in),
    .read_value_out (read_value_out),
    .leds_out       (leds_out),
    .timer_irq_out  (timer_irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Drive one bus cycle; expected read data is queued now and compared once
  // the edge that produces it has passed.
  task automatic step(input logic [31:0] a, input logic [31:0] wv, input logic [3:0] m,
                      input bit chk, input logic [31:0] exp, input string nm);
    logic [32:0] e;
    string       n;
    address_in     = a;
    write_value_in = wv;
    write_mask_in  = m;
    exp_q.push_back({chk, exp});
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    if (e[32]) check(n, read_value_out, e[31:0]);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wv;
    logic [3:0]  mask;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] v1, v2;

  initial begin
    vecs = '{
      '{32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0, 32'h0},
      '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0},
      '{32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEAA},
      '{32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_0000},
      '{32'h0000_0020, 32'h0000_0000, 4'h0, 1'b1, 32'h1234_5678},
      '{32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0},
      '{32'h0000_0014, 32'h1122_3344, 4'hA, 1'b1, 32'hFFFF_FFFF},
      '{32'h0000_0014, 32'h0000_0000, 4'h0, 1'b1, 32'h11FF_33FF},
      '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0},
      '{32'h0000_0FFC, 32'h0000_0000, 4'h0, 1'b1, 32'hCAFE_F00D},
      '{32'h0000_0000, 32'h0102_0304, 4'hF, 1'b0, 32'h0},
      '{32'h0000_1000, 32'h9999_9999, 4'hF, 1'b1, 32'h0000_0000},
      '{32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0102_0304},
      '{MMIO,          32'hFFFF_FF5A, 4'hF, 1'b1, 32'h0000_0000},
      '{MMIO,          32'h0000_0000, 4'h0, 1'b1, 32'h0000_005A},
      '{32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000},
      '{32'h8000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000},
      '{32'h8000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000},
      '{MMIO + 32'h10, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000},
      '{MMIO + 32'h8,  32'h00AB_0000, 4'h4, 1'b1, 32'hFFFF_FFFF},
      '{MMIO + 32'h8,  32'h0000_0000, 4'h0, 1'b1, 32'hFFAB_FFFF},
      '{MMIO + 32'hC,  32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000}
    };

    reset_n        = 1'b0;
    address_in     = 32'd0;
    write_value_in = 32'd0;
    write_mask_in  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", read_value_out, 32'd0);
    check("rst_leds", {24'd0, leds_out}, 32'd0);
    check("rst_irq", {31'd0, timer_irq_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_rdata", read_value_out, 32'd0);
    step(MMIO + 32'h8, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, "rst_cmp");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].addr, vecs[i].wv, vecs[i].mask, vecs[i].chk, vecs[i].exp,
           $sformatf("vec%0d", i));
    end
    check("leds_out", {24'd0, leds_out}, 32'h0000_005A);

    // Free-running counter advances by one per idle cycle
    step(MMIO + 32'h4, 32'd0, 4'h0, 1'b0, 32'd0, "cyc_a");
    v1 = read_value_out;
    step(MMIO + 32'h4, 32'd0, 4'h0, 1'b0, 32'd0, "cyc_b");
    v2 = read_value_out;
    check("cycle_incr", v2, v1 + 32'd1);

    // Wrap to zero matches CMP=0
    step(MMIO + 32'h4, 32'hFFFF_FFFD, 4'hF, 1'b0, 32'd0, "wr_cycle");
    step(MMIO + 32'h8, 32'h0000_0000, 4'hF, 1'b0, 32'd0, "wr_cmp");
    check("irq_before_wrap0", {31'd0, timer_irq_out}, 32'd0);
    step(MMIO + 32'h4, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFE, "cycle_fffe");
    check("irq_before_wrap1", {31'd0, timer_irq_out}, 32'd0);
    step(MMIO + 32'h4, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, "cycle_ffff");
    check("irq_at_wrap", {31'd0, timer_irq_out}, 32'd1);
    step(MMIO + 32'hC, 32'h0000_0000, 4'h1, 1'b1, 32'd1, "status_w0");
    check("irq_after_w0", {31'd0, timer_irq_out}, 32'd1);
    step(MMIO + 32'hC, 32'h0000_0001, 4'h1, 1'b1, 32'd1, "status_clr_rd");
    check("irq_cleared", {31'd0, timer_irq_out}, 32'd0);
    step(MMIO + 32'hC, 32'd0, 4'h0, 1'b1, 32'd0, "status_rd0");

    // Clear lands in the same cycle the counter reaches CMP: set wins
    step(MMIO + 32'h4, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'd0, "wr_cycle2");
    step(MMIO + 32'h0, 32'd0, 4'h0, 1'b1, 32'h0000_005A, "leds_rd");
    check("irq_pre_sim", {31'd0, timer_irq_out}, 32'd0);
    step(MMIO + 32'hC, 32'h0000_0001, 4'h1, 1'b1, 32'd0, "sim_setclr");
    check("irq_set_wins", {31'd0, timer_irq_out}, 32'd1);
    step(MMIO + 32'hC, 32'h0000_0001, 4'h1, 1'b1, 32'd1, "status_clr2");
    check("irq_cleared2", {31'd0, timer_irq_out}, 32'd0);

    // Writing CYCLE directly onto CMP also raises pending
    step(MMIO + 32'h4, 32'h0000_0000, 4'hF, 1'b0, 32'd0, "wr_cycle_eq");
    check("irq_on_cycle_wr", {31'd0, timer_irq_out}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
